// File: rtl/s298_obs_pkg.sv
// Shared types and constants for the s298 response compactor.
// Holds the FSM state encoding, response width and default MISR constants.
package s298_obs_pkg;

    localparam int          RESP_W       = 6;
    localparam logic [15:0] POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/s298_misr.sv
// Multiple-input signature register: shift left with POLY feedback, XOR in the response.
// Load restores the seed and takes priority over capture.
module s298_misr
    import s298_obs_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEFAULT,
    parameter logic [SIG_W-1:0] SEED  = SEED_DEFAULT
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s298_resp_compactor.sv
// Observation stage for s298: compacts a windowed stream of the six primary outputs
// into a MISR signature, tracks per-bit 0/1 observability, START/DONE handshake.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | no window; outputs hold reset or aborted partial values
//   ST_RUN  | capturing one response vector per clock (BUSY=1)
//   ST_DONE | window complete; SIG/CNT/OBS final until next START
module s298_resp_compactor
    import s298_obs_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEFAULT,
    parameter logic [SIG_W-1:0] SEED  = SEED_DEFAULT
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              START,
    input  logic              ABORT,
    input  logic [CNT_W-1:0]  LEN,
    input  logic              G66,
    input  logic              G67,
    input  logic              G117,
    input  logic              G118,
    input  logic              G132,
    input  logic              G133,
    output logic              BUSY,
    output logic              DONE,
    output logic [SIG_W-1:0]  SIG,
    output logic [CNT_W-1:0]  CNT,
    output logic [RESP_W-1:0] OBS0,
    output logic [RESP_W-1:0] OBS1
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    len_q;
    logic [RESP_W-1:0]   obs0_q, obs1_q;
    logic [RESP_W-1:0]   resp;
    logic                load;
    logic                cap;

    assign resp = {G133, G132, G118, G117, G67, G66};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every RUN cycle captures, including the one where ABORT is seen.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    load    = 1'b1;
                    state_d = (LEN == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cap = 1'b1;
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == len_q - CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt_q  <= '0;
            len_q  <= '0;
            obs0_q <= '0;
            obs1_q <= '0;
        end else if (load) begin
            cnt_q  <= '0;
            len_q  <= LEN;
            obs0_q <= '0;
            obs1_q <= '0;
        end else if (cap) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            obs0_q <= obs0_q | ~resp;
            obs1_q <= obs1_q | resp;
        end
    end

    s298_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CK   (CK),
        .RN   (RN),
        .load (load),
        .en   (cap),
        .resp (resp),
        .sig  (SIG)
    );

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign CNT  = cnt_q;
    assign OBS0 = obs0_q;
    assign OBS1 = obs1_q;

endmodule

// File: tb/tb_s298_resp_compactor.sv
// Directed bench for s298_resp_compactor with a scoreboard of expected window results.
module tb_s298_resp_compactor;

    localparam logic [15:0] SEED = 16'hFFFF;
    localparam logic [15:0] POLY = 16'h1021;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
        logic [5:0]  obs0;
        logic [5:0]  obs1;
    } exp_t;

    logic        CK = 1'b0;
    logic        RN;
    logic        START;
    logic        ABORT;
    logic [15:0] LEN;
    logic [5:0]  resp;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SIG;
    logic [15:0] CNT;
    logic [5:0]  OBS0;
    logic [5:0]  OBS1;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 CK = ~CK;

    s298_resp_compactor dut (
        .CK    (CK),
        .RN    (RN),
        .START (START),
        .ABORT (ABORT),
        .LEN   (LEN),
        .G66   (resp[0]),
        .G67   (resp[1]),
        .G117  (resp[2]),
        .G118  (resp[3]),
        .G132  (resp[4]),
        .G133  (resp[5]),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SIG   (SIG),
        .CNT   (CNT),
        .OBS0  (OBS0),
        .OBS1  (OBS1)
    );

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] r);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ POLY;
        return n ^ {10'd0, r};
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input logic exp_done);
        int   w;
        exp_t e;
        w = 0;
        while (exp_done && DONE !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        chk("done_flag", DONE, exp_done);
        chk("busy_end", BUSY, 1'b0);
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sig", SIG, e.sig);
            chk("cnt", CNT, e.cnt);
            chk("obs0", OBS0, e.obs0);
            chk("obs1", OBS1, e.obs1);
        end
    endtask

    // mode: 0 all-zero response, 1 all-ones, 2 random; start_at/abort_at are capture indices (-1 = none)
    task automatic run_window(input int len, input int mode, input int start_at, input int abort_at);
        logic [15:0] ms, mc;
        logic [5:0]  m0, m1;
        int          n;
        START = 1'b1;
        LEN   = len[15:0];
        resp  = '0;
        tick();
        START = 1'b0;
        LEN   = 16'hAAAA;
        chk("busy_start", BUSY, len != 0);
        ms = SEED;
        mc = '0;
        m0 = '0;
        m1 = '0;
        n  = (abort_at >= 0) ? abort_at + 1 : len;
        if (len == 0) exp_q.push_back('{ms, mc, m0, m1});
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       resp = 6'h00;
                1:       resp = 6'h3F;
                default: resp = 6'($urandom_range(0, 63));
            endcase
            START = (i == start_at);
            ABORT = (i == abort_at);
            ms = misr_step(ms, resp);
            mc = mc + 16'd1;
            m0 = m0 | ~resp;
            m1 = m1 | resp;
            if (i == n - 1) exp_q.push_back('{ms, mc, m0, m1});
            tick();
            START = 1'b0;
            ABORT = 1'b0;
            if (i < n - 1) chk("busy_mid", BUSY, 1'b1);
        end
        resp = '0;
        collect(abort_at < 0);
    endtask

    initial begin
        RN    = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        LEN   = '0;
        resp  = '0;
        #12;
        chk("rst_sig", SIG, 16'hFFFF);
        chk("rst_cnt", CNT, 16'd0);
        chk("rst_obs0", OBS0, 6'h00);
        chk("rst_obs1", OBS1, 6'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        @(negedge CK);
        RN = 1'b1;
        tick();

        run_window(1, 0, -1, -1);
        chk("len1_r0_sig", SIG, 16'hEFDF);
        chk("len1_r0_cnt", CNT, 16'd1);
        chk("len1_r0_obs0", OBS0, 6'h3F);
        chk("len1_r0_obs1", OBS1, 6'h00);
        tick();
        tick();
        chk("done_hold", DONE, 1'b1);
        chk("done_hold_sig", SIG, 16'hEFDF);

        run_window(0, 0, -1, -1);
        chk("len0_sig", SIG, 16'hFFFF);
        chk("len0_cnt", CNT, 16'd0);

        run_window(3, 1, -1, -1);
        chk("restart_obs0_cleared", OBS0, 6'h00);
        chk("restart_obs1", OBS1, 6'h3F);

        run_window(1, 1, -1, -1);
        chk("len1_r1_sig", SIG, 16'hEFE0);

        run_window(2, 0, -1, -1);
        chk("len2_sig", SIG, 16'hCF9F);
        chk("len2_cnt", CNT, 16'd2);

        run_window(5, 2, -1, 1);
        chk("abort_cnt", CNT, 16'd2);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
        chk("abort_idle_done", DONE, 1'b0);
        chk("abort_idle_cnt", CNT, 16'd2);

        run_window(5, 2, 2, -1);
        chk("start_ignored_cnt", CNT, 16'd5);

        run_window(3, 2, -1, 2);
        chk("abort_last_cnt", CNT, 16'd3);

        run_window(7, 2, -1, -1);

        START = 1'b1;
        LEN   = 16'd4;
        tick();
        START = 1'b0;
        resp  = 6'($urandom_range(0, 63));
        tick();
        #2;
        RN = 1'b0;
        #1;
        chk("midrst_sig", SIG, 16'hFFFF);
        chk("midrst_cnt", CNT, 16'd0);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_done", DONE, 1'b0);
        RN = 1'b1;
        tick();
        chk("postrst_cnt", CNT, 16'd0);
        chk("postrst_sig", SIG, 16'hFFFF);
        chk("postrst_busy", BUSY, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s298_resp_compactor.md
# s298_resp_compactor

Downstream observation stage for the s298 sequential benchmark. It consumes the six primary outputs (G66, G67, G117, G118, G132, G133) every clock and compacts a software-chosen window of them into a multiple-input signature register (MISR). It also records per-output 0/1 observability and hands the finished signature to the property/assertion harness through a START/DONE handshake.

## Interface
- SIG_W, 16, signature width; must be ≥ 6.
- CNT_W, 16, width of the window length and cycle counter.
- POLY, 16'h1021, MISR feedback tap mask, SIG_W bits.
- SEED, 16'hFFFF, signature value loaded at window start.
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- START  input  1  begin a window; honoured only in IDLE or DONE.
- ABORT  input  1  terminate a running window; honoured only in RUN.
- LEN  input  CNT_W  number of capture cycles, sampled with START.
- G66, G67, G117, G118, G132, G133  input  1 each  s298 outputs.
- BUSY  output  1  high while in RUN.
- DONE  output  1  high while in DONE.
- SIG  output  SIG_W  current or final signature.
- CNT  output  CNT_W  captures performed in the current or last window.
- OBS0  output  6  bit i set once response bit i has been sampled 0 in the window.
- OBS1  output  6  bit i set once response bit i has been sampled 1 in the window.

## Operation
- Response vector R[5:0] = {G133, G132, G118, G117, G67, G66}, so bit 0 is G66.
- Three-state FSM:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1, DONE=0.
  - DONE: BUSY=0, DONE=1.
- START while in IDLE or DONE:
  - SIG←SEED, CNT←0, OBS0←0, OBS1←0.
  - If LEN≠0, go to RUN. If LEN=0, go straight to DONE with SIG=SEED and CNT=0.
  - LEN is latched internally; later LEN changes are ignored.
- Each RUN cycle:
  - SIG←({SIG[SIG_W-2:0],0} ^ (SIG[SIG_W-1] ? POLY : 0) ^ zero-extended R).
  - CNT←CNT+1.
  - OBS0|=~R, OBS1|=R.
- When the capture being performed is the LEN-th, go to DONE.
- START during RUN is ignored.
- ABORT during RUN: go to IDLE. SIG, CNT and OBS hold their partial values; DONE stays 0.
- If ABORT and the final capture coincide, ABORT wins: the capture still occurs, then the FSM goes to IDLE.
- ABORT outside RUN has no effect.
- DONE state holds all outputs until the next START.
- CNT cannot wrap, because LEN ≤ 2^CNT_W−1.

## Timing
- Reset (RN=0, asynchronous):
  - FSM=IDLE, BUSY=0, DONE=0.
  - SIG=SEED, CNT=0, OBS0=0, OBS1=0.
  - Release of reset is synchronous to CK.
- START sampled at edge k with LEN=N≥1:
  - BUSY rises after edge k.
  - R is captured at edges k+1 … k+N.
  - BUSY falls and DONE rises after edge k+N.
  - SIG/CNT are final in the same cycle that DONE rises.
- LEN=0: DONE rises after edge k.
- All outputs are registered; there is no combinational path from the inputs to any output.
- Reset asserted mid-window: immediate return to reset values; the window is lost.

## Structure
- Package s298_obs_pkg:
  - State enum {IDLE, RUN, DONE}.
  - RESP_W=6.
  - Default POLY and SEED constants.
- Sub-module s298_misr: SIG_W-wide MISR with load (seed), enable and RESP_W-bit parallel input.
- The top level holds the FSM, counter and OBS flags.

## Test plan
- Reset with RN=0 mid-RUN → SIG=FFFF, CNT=0, BUSY=0, DONE=0 immediately; no capture on the next edge.
- START, LEN=1, R=0 → DONE after edge k+1, SIG=EFDF, CNT=1, OBS0=3F, OBS1=00.
- START, LEN=1, all six outputs 1 → SIG=EFE0, OBS0=00, OBS1=3F.
- START, LEN=2, R=0 both cycles → SIG=CF9F, CNT=2; BUSY high for exactly 2 cycles.
- START with LEN=0 → DONE one cycle later, SIG=FFFF, CNT=0. Then START with LEN=3 from DONE → new window runs and OBS flags are cleared.
- LEN=5 run:
  - ABORT after 2 captures → IDLE, CNT=2, DONE never asserted.
  - START pulsed during RUN → ignored, CNT still counts to LEN.
